// File: rtl/layer_out_serializer.sv
// Captures one layer's parallel neuron outputs and replays them as a serial word stream, neuron 0 first.
// Optional one-deep pending vector buffer enabled by defining SER_PENDING_BUF_EN.
module layer_out_serializer #(
  parameter int numNeurons = 30,
  parameter int dataWidth  = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [numNeurons-1:0]           x_valid,
  input  logic [numNeurons*dataWidth-1:0] x_in,
  output logic [dataWidth-1:0]            data_out,
  output logic                            data_out_valid,
  output logic                            busy,
  output logic                            overrun,
  output logic                            valid_err
);

  localparam int IDX_W = $clog2(numNeurons);
  localparam int VEC_W = numNeurons * dataWidth;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(numNeurons - 1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t            state;
  logic [IDX_W-1:0]  idx;
  logic [VEC_W-1:0]  shift_buf;
  logic              cap;
  logic              last;
  logic              load_new;
  logic              load_pend;
  logic              drop;
  logic              pend_full;

  assign cap  = x_valid[0];
  assign last = (state == SEND) && (idx == LAST_IDX);

`ifdef SER_PENDING_BUF_EN
  logic [VEC_W-1:0] pend_buf;
  logic             store_pend;

  // An early vector parks in pending; only a second early vector is lost.
  assign store_pend = cap && (state == SEND) && !last && !pend_full;
  assign drop       = cap && (state == SEND) && !last && pend_full;

  always_ff @(posedge clk) begin
    if (store_pend) pend_buf <= x_in;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_full <= 1'b0;
    end else if (store_pend) begin
      pend_full <= 1'b1;
    end else if (load_pend) begin
      pend_full <= 1'b0;
    end
  end
`else
  assign pend_full = 1'b0;
  assign drop      = cap && (state == SEND) && !last;
`endif

  // A capture on the last word takes priority so the stream continues with no gap.
  assign load_new  = cap && ((state == IDLE) || last);
  assign load_pend = last && !cap && pend_full;

  // NOTE: data buffers carry no reset; state and valid flags alone decide whether their contents are ever used.
  always_ff @(posedge clk) begin
    if (load_new) begin
      shift_buf <= x_in;
`ifdef SER_PENDING_BUF_EN
    end else if (load_pend) begin
      shift_buf <= pend_buf;
`endif
    end
  end

  // NOTE: all sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      idx            <= '0;
      data_out       <= '0;
      data_out_valid <= 1'b0;
      busy           <= 1'b0;
      overrun        <= 1'b0;
      valid_err      <= 1'b0;
    end else begin
      if ((x_valid != '0) && (x_valid != '1)) valid_err <= 1'b1;
      if (drop) overrun <= 1'b1;
      data_out_valid <= (state == SEND);
      busy           <= (state == SEND);
      unique case (state)
        IDLE: begin
          if (cap) begin
            idx   <= '0;
            state <= SEND;
          end
        end
        SEND: begin
          data_out <= shift_buf[idx*dataWidth +: dataWidth];
          if (!last) begin
            idx <= idx + 1'b1;
          end else begin
            idx <= '0;
            if (!cap && !load_pend) state <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_layer_out_serializer.sv
// Self-checking bench for layer_out_serializer: table-driven vectors on a 4-neuron instance,
// hand-written sequences for reset, early vectors and a 30-neuron instance.
module tb_layer_out_serializer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic [3:0]  x_valid4 = '0;
  logic [63:0] x_in4    = '0;
  logic [15:0] dout4;
  logic        dv4, busy4, ovr4, verr4;

  logic [29:0]  x_valid30 = '0;
  logic [479:0] x_in30    = '0;
  logic [15:0]  dout30;
  logic         dv30, busy30, ovr30, verr30;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  layer_out_serializer #(.numNeurons(4), .dataWidth(16)) dut4 (
    .clk(clk), .rst(rst), .x_valid(x_valid4), .x_in(x_in4),
    .data_out(dout4), .data_out_valid(dv4), .busy(busy4),
    .overrun(ovr4), .valid_err(verr4)
  );

  layer_out_serializer #(.numNeurons(30), .dataWidth(16)) dut30 (
    .clk(clk), .rst(rst), .x_valid(x_valid30), .x_in(x_in30),
    .data_out(dout30), .data_out_valid(dv30), .busy(busy30),
    .overrun(ovr30), .valid_err(verr30)
  );

  typedef struct {
    logic [3:0]  xv;
    logic [63:0] xi;
    logic [15:0] e_data;
    logic        e_v;
    logic        e_busy;
    logic        e_ovr;
    logic        e_verr;
  } vec_t;

  vec_t tbl[22];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] pack4(input logic [15:0] w0, w1, w2, w3);
    return {w3, w2, w1, w0};
  endfunction

  function automatic vec_t mk(input logic [3:0] xv, input logic [63:0] xi, input logic [15:0] d,
                              input logic v, b, o, e);
    vec_t r;
    r.xv = xv; r.xi = xi; r.e_data = d; r.e_v = v; r.e_busy = b; r.e_ovr = o; r.e_verr = e;
    return r;
  endfunction

  // Drive the 4-neuron inputs away from the edge, then sample just after the next edge.
  task automatic step(input logic [3:0] xv, input logic [63:0] xi);
    @(negedge clk);
    x_valid4 = xv;
    x_in4    = xi;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [63:0] va, vb, vc, vd, ve, vf, vg, vh, vi;
    logic [15:0] gw[4];
    logic [15:0] hw[4];
    logic [15:0] fw[4];
    int          n_exp;

    va = pack4(16'h0011, 16'h0022, 16'h0033, 16'h0044);
    vb = pack4(16'h0101, 16'h0202, 16'h0303, 16'h0404);
    vc = pack4(16'h00A1, 16'h00A2, 16'h00A3, 16'h00A4);
    vd = pack4(16'h0D01, 16'h0D02, 16'h0D03, 16'h0D04);
    fw = '{16'h0E10, 16'h0E20, 16'h0E30, 16'h0E40};
    gw = '{16'h1001, 16'h1002, 16'h1003, 16'h1004};
    hw = '{16'h2001, 16'h2002, 16'h2003, 16'h2004};
    ve = pack4(16'h0E01, 16'h0E02, 16'h0E03, 16'h0E04);
    vf = pack4(fw[0], fw[1], fw[2], fw[3]);
    vg = pack4(gw[0], gw[1], gw[2], gw[3]);
    vh = pack4(hw[0], hw[1], hw[2], hw[3]);
    vi = pack4(16'h3001, 16'h3002, 16'h3003, 16'h3004);

    // Single vector, back-to-back pair, mismatched valids.
    tbl[0]  = mk(4'hF, va, 16'h0000, 0, 0, 0, 0);
    tbl[1]  = mk(4'h0, '0, 16'h0011, 1, 1, 0, 0);
    tbl[2]  = mk(4'h0, '0, 16'h0022, 1, 1, 0, 0);
    tbl[3]  = mk(4'h0, '0, 16'h0033, 1, 1, 0, 0);
    tbl[4]  = mk(4'h0, '0, 16'h0044, 1, 1, 0, 0);
    tbl[5]  = mk(4'h0, '0, 16'h0044, 0, 0, 0, 0);
    tbl[6]  = mk(4'hF, vb, 16'h0044, 0, 0, 0, 0);
    tbl[7]  = mk(4'h0, '0, 16'h0101, 1, 1, 0, 0);
    tbl[8]  = mk(4'h0, '0, 16'h0202, 1, 1, 0, 0);
    tbl[9]  = mk(4'h0, '0, 16'h0303, 1, 1, 0, 0);
    tbl[10] = mk(4'hF, vc, 16'h0404, 1, 1, 0, 0);
    tbl[11] = mk(4'h0, '0, 16'h00A1, 1, 1, 0, 0);
    tbl[12] = mk(4'h0, '0, 16'h00A2, 1, 1, 0, 0);
    tbl[13] = mk(4'h0, '0, 16'h00A3, 1, 1, 0, 0);
    tbl[14] = mk(4'h0, '0, 16'h00A4, 1, 1, 0, 0);
    tbl[15] = mk(4'h0, '0, 16'h00A4, 0, 0, 0, 0);
    tbl[16] = mk(4'h5, vd, 16'h00A4, 0, 0, 0, 1);
    tbl[17] = mk(4'h0, '0, 16'h0D01, 1, 1, 0, 1);
    tbl[18] = mk(4'h0, '0, 16'h0D02, 1, 1, 0, 1);
    tbl[19] = mk(4'h0, '0, 16'h0D03, 1, 1, 0, 1);
    tbl[20] = mk(4'h0, '0, 16'h0D04, 1, 1, 0, 1);
    tbl[21] = mk(4'h0, '0, 16'h0D04, 0, 0, 0, 1);

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check("reset data_out", 32'(dout4), 32'h0);
    check("reset valid", 32'(dv4), 32'h0);
    check("reset busy", 32'(busy4), 32'h0);
    check("reset overrun", 32'(ovr4), 32'h0);
    check("reset valid_err", 32'(verr4), 32'h0);
    check("reset valid n30", 32'(dv30), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 22; i++) begin
      step(tbl[i].xv, tbl[i].xi);
      check($sformatf("row%0d data", i), 32'(dout4), 32'(tbl[i].e_data));
      check($sformatf("row%0d valid", i), 32'(dv4), 32'(tbl[i].e_v));
      check($sformatf("row%0d busy", i), 32'(busy4), 32'(tbl[i].e_busy));
      check($sformatf("row%0d overrun", i), 32'(ovr4), 32'(tbl[i].e_ovr));
      check($sformatf("row%0d valid_err", i), 32'(verr4), 32'(tbl[i].e_verr));
    end

    // Reset mid-stream while word 2 is on the output.
    step(4'hF, ve);
    step(4'h0, '0);
    check("mid e0", 32'(dout4), 32'h0E01);
    step(4'h0, '0);
    step(4'h0, '0);
    check("mid e2", 32'(dout4), 32'h0E03);
    check("mid e2 valid", 32'(dv4), 32'h1);
    #1 rst = 1'b1;
    #1;
    check("async rst data", 32'(dout4), 32'h0);
    check("async rst valid", 32'(dv4), 32'h0);
    check("async rst busy", 32'(busy4), 32'h0);
    check("async rst valid_err", 32'(verr4), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step(4'h0, '0);
      check($sformatf("post rst idle %0d", k), 32'(dv4), 32'h0);
    end
    step(4'hF, vf);
    check("restart capture valid", 32'(dv4), 32'h0);
    for (int k = 0; k < 4; k++) begin
      step(4'h0, '0);
      check($sformatf("restart word%0d", k), 32'(dout4), 32'(fw[k]));
      check($sformatf("restart valid%0d", k), 32'(dv4), 32'h1);
    end
    step(4'h0, '0);
    check("restart end valid", 32'(dv4), 32'h0);
    check("restart end busy", 32'(busy4), 32'h0);

    // Early second vector at word 1, then a third while pending would be full.
`ifdef SER_PENDING_BUF_EN
    n_exp = 8;
`else
    n_exp = 4;
`endif
    step(4'hF, vg);
    for (int k = 1; k <= 10; k++) begin
      step((k == 2 || k == 3) ? 4'hF : 4'h0, (k == 2) ? vh : (k == 3) ? vi : 64'h0);
      check($sformatf("early valid k%0d", k), 32'(dv4), (k <= n_exp) ? 32'h1 : 32'h0);
      if (k <= n_exp)
        check($sformatf("early data k%0d", k), 32'(dout4), (k <= 4) ? 32'(gw[k-1]) : 32'(hw[k-5]));
      if (k == 2)
        check("early overrun second", 32'(ovr4), (n_exp == 8) ? 32'h0 : 32'h1);
      if (k == 3)
        check("early overrun third", 32'(ovr4), 32'h1);
      if (k == n_exp + 1)
        check("early busy end", 32'(busy4), 32'h0);
    end

    // 30 neurons, word k = k.
    for (int k = 0; k < 30; k++) x_in30[k*16 +: 16] = 16'(k);
    @(negedge clk);
    x_valid30 = '1;
    @(posedge clk);
    #1;
    check("n30 capture valid", 32'(dv30), 32'h0);
    @(negedge clk);
    x_valid30 = '0;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("n30 word%0d", k), 32'(dout30), 32'(k));
      check($sformatf("n30 valid%0d", k), 32'(dv30), 32'h1);
    end
    @(posedge clk);
    #1;
    check("n30 end valid", 32'(dv30), 32'h0);
    check("n30 end busy", 32'(busy30), 32'h0);
    check("n30 overrun", 32'(ovr30), 32'h0);
    check("n30 valid_err", 32'(verr30), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
